// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: oversampling UART receiver. 8 data bits LSB first, optional
// even/odd parity and one stop bit. A bit is the 3-sample majority taken
// around its centre. Results appear as one-cycle pulses one clock after the
// stop-bit decision.
module uart_rx #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [7:0]            p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   localparam logic [PRESCALE_W-1:0] ONE_P = PRESCALE_W'(1);
   localparam logic [PRESCALE_W-1:0] P8    = PRESCALE_W'(8);
   localparam logic [PRESCALE_W-1:0] P16   = PRESCALE_W'(16);
   localparam logic [PRESCALE_W-1:0] P32   = PRESCALE_W'(32);

   state_t                  state, next_state;
   logic                    rx_s1, rx_s2, rx_prev;
   logic [PRESCALE_W-1:0]   p_q, p_sel, half;
   logic                    par_en_q, par_typ_q;
   logic [PRESCALE_W-1:0]   edge_cnt;
   logic [2:0]              bit_cnt;
   logic                    samp0, samp1, maj, fall;
   logic                    at_s0, at_s1, at_dec, at_last;
   logic [7:0]              shift_q;
   logic                    par_bad;

   assign half    = p_q >> 1;
   assign at_s0   = (edge_cnt == half - ONE_P);
   assign at_s1   = (edge_cnt == half);
   assign at_dec  = (edge_cnt == half + ONE_P);
   assign at_last = (edge_cnt == p_q - ONE_P);
   assign maj     = (samp0 & samp1) | (samp0 & rx_s2) | (samp1 & rx_s2);
   assign fall    = rx_prev & ~rx_s2;
   assign busy    = (state != IDLE);

   // Map an illegal oversampling ratio onto 8.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      p_sel = P8;
      if (prescale == P16 || prescale == P32) p_sel = prescale;
   end

   // Two-flop synchronizer plus previous sample for falling-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx_in;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next-state logic; STOP leaves at the decision cycle so a start bit in the
   // second half of the stop bit is still caught.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (fall) next_state = START;
         START: if (at_dec && maj) next_state = IDLE;
                else if (at_last)  next_state = DATA;
         DATA:  if (at_last && bit_cnt == 3'd7) next_state = par_en_q ? PAR : STOP;
         PAR:   if (at_last) next_state = STOP;
         STOP:  if (at_dec)  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Frame configuration is frozen at the start-bit edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q       <= P8;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else if (state == IDLE && fall) begin
         p_q       <= p_sel;
         par_en_q  <= par_en;
         par_typ_q <= par_typ;
      end
   end

   // Oversampling and data-bit counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_cnt <= '0;
         bit_cnt  <= 3'd0;
      end else begin
         if (state == IDLE || next_state == IDLE) edge_cnt <= '0;
         else if (at_last)                        edge_cnt <= '0;
         else                                     edge_cnt <= edge_cnt + ONE_P;
         if (state != DATA) bit_cnt <= 3'd0;
         else if (at_last)  bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // Centre samples, data shift register and parity check.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the shift register is small, so it is reset along with the control state.
         samp0   <= 1'b1;
         samp1   <= 1'b1;
         shift_q <= 8'h00;
         par_bad <= 1'b0;
      end else begin
         if (state != IDLE && at_s0) samp0 <= rx_s2;
         if (state != IDLE && at_s1) samp1 <= rx_s2;
         if (state == DATA && at_dec) shift_q[bit_cnt] <= maj;
         if (state == START)
            par_bad <= 1'b0;
         else if (state == PAR && at_dec)
            par_bad <= maj ^ (par_typ_q ? ~^shift_q : ^shift_q);
      end
   end

   // Result pulses, registered one clock after the stop-bit decision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_data     <= 8'h00;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         if (state == STOP && at_dec) begin
            stp_err <= ~maj;
            par_err <= par_bad;
            if (maj && !par_bad) begin
               data_valid <= 1'b1;
               p_data     <= shift_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed testbench for uart_rx: frames at each legal oversampling ratio,
// parity and stop errors, glitch rejection, back-to-back frames, held-low
// line, mid-frame configuration changes and mid-frame reset.
module tb_uart_rx;

   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx_in = 1'b1;
   logic [PW-1:0] prescale = PW'(16);
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic [7:0]    p_data;
   logic          data_valid, par_err, stp_err, busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cyc = 0;
   int dv_last = 0, pe_last = 0, se_last = 0;
   int dv_q[$];
   int start_cyc = 0;
   int dv0, pe0, se0, b0;
   int gap;

   uart_rx #(.PRESCALE_W(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse and busy monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (data_valid) begin dv_cnt++; dv_last = cyc; dv_q.push_back(cyc); end
      if (par_err)    begin pe_cnt++; pe_last = cyc; end
      if (stp_err)    begin se_cnt++; se_last = cyc; end
      if (busy)       busy_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; b0 = busy_cyc;
   endtask

   // Drive one frame with p clocks per bit; optionally disturb the
   // configuration ports after data bit 2 has started.
   task automatic send_frame(input logic [7:0] d, input bit use_par, input bit pbit,
                             input bit stop, input int p, input bit mid_chg);
      start_cyc = cyc;
      rx_in = 1'b0;
      tick(p);
      for (int i = 0; i < 8; i++) begin
         rx_in = d[i];
         if (mid_chg && i == 2) begin
            prescale = PW'(8);
            par_en   = 1'b1;
            par_typ  = 1'b1;
         end
         tick(p);
      end
      if (use_par) begin
         rx_in = pbit;
         tick(p);
      end
      rx_in = stop;
      tick(p);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tick(3);
      // Reset state
      check("rst_p_data", p_data, 8'h00);
      check("rst_data_valid", data_valid, 1'b0);
      check("rst_par_err", par_err, 1'b0);
      check("rst_stp_err", stp_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b1;
      tick(4);

      // P=16, no parity, 0xA5
      snap();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, 1'b0);
      rx_in = 1'b1;
      tick(32);
      check("a5_p_data", p_data, 8'hA5);
      check("a5_valid_cnt", dv_cnt - dv0, 1);
      check("a5_no_err", (pe_cnt - pe0) + (se_cnt - se0), 0);
      check("a5_latency", dv_last, start_cyc + 5 + 9 * 16 + 8);

      // P=8, even parity, 0x3C good then bad parity
      prescale = PW'(8); par_en = 1'b1; par_typ = 1'b0;
      snap();
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 8, 1'b0);
      rx_in = 1'b1;
      tick(16);
      check("3c_valid_cnt", dv_cnt - dv0, 1);
      check("3c_p_data", p_data, 8'h3C);
      snap();
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 8, 1'b0);
      rx_in = 1'b1;
      tick(16);
      check("3c_par_err_cnt", pe_cnt - pe0, 1);
      check("3c_par_err_time", pe_last, start_cyc + 5 + 10 * 8 + 4);
      check("3c_bad_no_valid", dv_cnt - dv0, 0);
      check("3c_bad_no_stp", se_cnt - se0, 0);
      check("3c_p_data_kept", p_data, 8'h3C);

      // P=32, odd parity, 0x01 good then stop bit low
      prescale = PW'(32); par_typ = 1'b1;
      snap();
      send_frame(8'h01, 1'b1, 1'b0, 1'b1, 32, 1'b0);
      rx_in = 1'b1;
      tick(64);
      check("01_valid_cnt", dv_cnt - dv0, 1);
      check("01_p_data", p_data, 8'h01);
      check("01_no_par_err", pe_cnt - pe0, 0);
      snap();
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, 32, 1'b0);
      rx_in = 1'b1;
      tick(64);
      check("stp_err_cnt", se_cnt - se0, 1);
      check("stp_err_time", se_last, start_cyc + 5 + 10 * 32 + 16);
      check("stp_no_valid", dv_cnt - dv0, 0);
      check("stp_no_par_err", pe_cnt - pe0, 0);

      // Two-clock low glitch at P=16
      prescale = PW'(16); par_en = 1'b0; par_typ = 1'b0;
      snap();
      rx_in = 1'b0;
      tick(2);
      rx_in = 1'b1;
      tick(40);
      check("glitch_busy_seen", (busy_cyc - b0) > 0, 1'b1);
      check("glitch_busy_max", (busy_cyc - b0) <= 10, 1'b1);
      check("glitch_no_pulse", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
      check("glitch_idle", busy, 1'b0);

      // Back-to-back 0x55 then 0xAA, no idle gap
      snap();
      dv_q.delete();
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 16, 1'b0);
      send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 16, 1'b0);
      rx_in = 1'b1;
      tick(32);
      check("b2b_valid_cnt", dv_cnt - dv0, 2);
      gap = (dv_q.size() >= 2) ? dv_q[1] - dv_q[0] : -1;
      check("b2b_gap", gap, 160);
      check("b2b_p_data", p_data, 8'hAA);

      // Line held low: a single stop error, no second start
      snap();
      rx_in = 1'b0;
      tick(25 * 16);
      rx_in = 1'b1;
      tick(32);
      check("hold_stp_cnt", se_cnt - se0, 1);
      check("hold_no_valid", dv_cnt - dv0, 0);
      check("hold_idle", busy, 1'b0);

      // Configuration changed mid-frame has no effect on that frame
      snap();
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 16, 1'b1);
      rx_in = 1'b1;
      tick(32);
      check("midcfg_valid_cnt", dv_cnt - dv0, 1);
      check("midcfg_p_data", p_data, 8'h5A);
      check("midcfg_no_err", (pe_cnt - pe0) + (se_cnt - se0), 0);

      // Illegal prescale is treated as 8
      prescale = PW'(12); par_en = 1'b0;
      snap();
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      rx_in = 1'b1;
      tick(16);
      check("illegal_ps_valid", dv_cnt - dv0, 1);
      check("illegal_ps_p_data", p_data, 8'hC3);

      // Reset during data bit 4, then 0x81
      prescale = PW'(16);
      snap();
      rx_in = 1'b0;
      tick(16);
      rx_in = 1'b1;
      tick(4 * 16);
      rx_in = 1'b0;
      tick(8);
      rst = 1'b0;
      #2;
      check("midrst_busy", busy, 1'b0);
      check("midrst_p_data", p_data, 8'h00);
      rx_in = 1'b1;
      tick(5);
      rst = 1'b1;
      tick(64);
      check("midrst_no_pulse", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
      snap();
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, 16, 1'b0);
      rx_in = 1'b1;
      tick(32);
      check("81_valid_cnt", dv_cnt - dv0, 1);
      check("81_p_data", p_data, 8'h81);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: PRESCALE_W, default 6, width of the prescale port.
REQ-002 Port: clk  in  1  single system clock, running at prescale times the bit rate; all state updates on posedge clk.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: rx_in  in  1  serial line; idles high.
REQ-005 Port: prescale  in  PRESCALE_W  oversampling ratio; legal values are 8, 16 and 32.
REQ-006 Port: par_en  in  1  1 means a parity bit follows the data bits.
REQ-007 Port: par_typ  in  1  0 selects even parity; 1 selects odd parity.
REQ-008 Port: p_data  out  8  received byte; holds its value until the next good frame.
REQ-009 Port: data_valid  out  1  one-cycle pulse marking a good frame.
REQ-010 Port: par_err  out  1  one-cycle pulse marking a parity mismatch.
REQ-011 Port: stp_err  out  1  one-cycle pulse marking a stop bit sampled low.
REQ-012 Port: busy  out  1  high whenever the FSM is outside IDLE.

Function
REQ-013 Frame format: start(0), then d0..d7 LSB first, then optional parity, then stop(1).
REQ-014 rx_in shall pass through a 2-flop synchronizer; all logic uses only the synchronized value.
REQ-015 On detection of a start bit, prescale, par_en and par_typ shall be latched; a prescale value other than 8, 16 or 32 shall be latched as 8.
REQ-016 Counters:
- edge_cnt counts 0..P-1 per bit, where P is the latched prescale, and wraps at P-1.
- bit_cnt counts the data bits 0..7.
REQ-017 Sampling: the line shall be sampled at edge_cnt = P/2-1, P/2 and P/2+1; the bit value is the majority of the three samples, decided at edge_cnt = P/2+1.
REQ-018 FSM states: IDLE, START, DATA, PAR, STOP.
REQ-019 IDLE -> START on a synchronized falling edge (previous sample 1, current sample 0); edge_cnt is cleared to 0 on entry.
REQ-020 START:
- Majority 1 (glitch): go to IDLE at the decision cycle; no output pulse.
- Majority 0: go to DATA at edge_cnt = P-1.
REQ-021 DATA: each decided bit shifts into an internal shift register at bit position bit_cnt; after bit 7 at edge_cnt = P-1, go to PAR if par_en is latched, otherwise go to STOP.
REQ-022 PAR: expected parity bit = ^data for even, ~^data for odd; compare with the sampled bit and go to STOP at edge_cnt = P-1.
REQ-023 STOP decision cycle: the FSM returns to IDLE in the same cycle, so it can detect a start bit beginning in the second half of the stop bit. In the following cycle exactly one of these occurs:
- Stop bit 1 and parity ok: data_valid pulses and p_data loads the shifted byte.
- Parity mismatch: par_err pulses; p_data is unchanged.
- Stop bit 0: stp_err pulses; p_data is unchanged. par_err may also pulse in the same cycle if parity failed too.
REQ-024 Latency: data_valid follows the stop-bit decision cycle by exactly 1 clk.
REQ-025 Changes to prescale, par_en or par_typ during a frame shall have no effect until the next start bit.
REQ-026 A line held low continuously shall yield a stp_err pulse, then the FSM waits in IDLE for a fresh falling edge; the held-low line shall not be counted as a second start bit.

Reset
REQ-027 While rst = 0:
- Outputs: p_data = 8'h00; data_valid, par_err, stp_err and busy = 0.
- FSM = IDLE; counters = 0; synchronizer flops and previous sample = 1.
REQ-028 Reset asserted mid-frame shall abort the frame immediately with no error or valid pulse.
REQ-029 After reset release, the first frame is accepted only from a new falling edge.

Verification
REQ-030 P=16, par_en=0: send 0xA5 -> p_data=0xA5, one data_valid pulse 1 clk after the stop decision; par_err=0 and stp_err=0.
REQ-031 P=8, par_en=1, par_typ=0: send 0x3C with parity 0 -> valid; send 0x3C with parity 1 -> par_err pulse, p_data keeps 0x3C from the prior frame.
REQ-032 P=32, par_en=1, par_typ=1: send 0x01 with parity bit 0 -> valid, p_data=0x01; send stop=0 -> stp_err pulse and no data_valid.
REQ-033 Low glitch of 2 clk on an idle line at P=16 -> FSM returns to IDLE, no pulses, busy high for at most P/2+2 clk.
REQ-034 Back-to-back frames 0x55 then 0xAA at P=16 with zero idle gap -> two data_valid pulses, one per frame, 10*16 clk apart.
REQ-035 rst pulled low at bit 4 of a frame, then released, then 0x81 sent -> no pulse for the aborted frame; 0x81 is received correctly.
